// File: rtl/fifo_frame_reader.sv
// Drains a COREFIFO read port and frames it as HEADER, payload words, TRAILER on a valid/ready stream.
// First payload word appears RD_LATENCY+1 cycles after the header transfers; reads are credit-limited by the skid buffer.
module fifo_frame_reader #(
    parameter int         RD_LATENCY = 1,
    parameter int         LEN_WIDTH  = 16,
    parameter int         TO_WIDTH   = 16,
    parameter logic [7:0] SYNC_HDR   = 8'hA5,
    parameter logic [7:0] SYNC_TRL   = 8'h5A
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 ENABLE,
    input  logic [7:0]           CHANNEL_ID,
    input  logic [LEN_WIDTH-1:0] FRAME_LEN,
    input  logic [TO_WIDTH-1:0]  TIMEOUT,
    input  logic                 FIFO_EMPTY,
    input  logic [63:0]          FIFO_Q,
    output logic                 FIFO_RE,
    output logic [63:0]          OUT_DATA,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic                 OUT_LAST,
    output logic                 BUSY,
    output logic [15:0]          FRAME_SEQ
);

    localparam int DEPTH = RD_LATENCY + 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int OW    = CW + 1;
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PAYLOAD, S_TRAILER} state_t;

    state_t                state;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  sent;
    logic [LEN_WIDTH-1:0]  issued;
    logic [7:0]            chan_q;
    logic [15:0]           seq_q;
    logic [TO_WIDTH-1:0]   stall_cnt;
    logic                  to_flag;
    logic [63:0]           skid_mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         buf_cnt;
    logic [RD_LATENCY-1:0] re_pipe;
    logic [CW-1:0]         inflight;
    logic [OW-1:0]         occ;
    logic                  pop;
    logic                  push;
    logic                  rd_fire;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + CW'(re_pipe[i]);
        end
    end

    assign pop  = (state == S_PAYLOAD) && (buf_cnt != '0) && OUT_READY;
    assign push = re_pipe[RD_LATENCY-1];

    // A word leaving this cycle frees its slot, so back-to-back reads never leave a bubble.
    assign occ     = OW'(buf_cnt) - OW'(pop) + OW'(inflight);
    assign rd_fire = !RESET && (state == S_PAYLOAD) && !FIFO_EMPTY && (issued < len_q)
                     && !to_flag && (occ < OW'(DEPTH));
    assign FIFO_RE = rd_fire;

    always_comb begin
        OUT_DATA  = '0;
        OUT_VALID = 1'b0;
        OUT_LAST  = 1'b0;
        case (state)
            S_HEADER: begin
                OUT_DATA  = {SYNC_HDR, chan_q, seq_q, 16'(len_q), 16'h0};
                OUT_VALID = 1'b1;
            end
            S_PAYLOAD: begin
                OUT_DATA  = (buf_cnt != '0) ? skid_mem[rd_ptr] : '0;
                OUT_VALID = (buf_cnt != '0);
            end
            S_TRAILER: begin
                OUT_DATA  = {SYNC_TRL, chan_q, seq_q, 16'(sent), 15'h0, to_flag};
                OUT_VALID = 1'b1;
                OUT_LAST  = 1'b1;
            end
            default: ;
        endcase
    end

    assign BUSY      = (state != S_IDLE);
    assign FRAME_SEQ = seq_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= S_IDLE;
            len_q     <= '0;
            sent      <= '0;
            issued    <= '0;
            chan_q    <= '0;
            seq_q     <= '0;
            stall_cnt <= '0;
            to_flag   <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            buf_cnt   <= '0;
            re_pipe   <= '0;
        end else begin
            re_pipe[0] <= rd_fire;
            for (int i = 1; i < RD_LATENCY; i++) begin
                re_pipe[i] <= re_pipe[i-1];
            end

            if (push) begin
                skid_mem[wr_ptr] <= FIFO_Q;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
                sent   <= sent + LEN_WIDTH'(1);
            end
            buf_cnt <= buf_cnt + CW'(push) - CW'(pop);
            if (rd_fire) begin
                issued <= issued + LEN_WIDTH'(1);
            end

            // Stall watchdog only runs while the frame still owes reads from the FIFO.
            if (rd_fire) begin
                stall_cnt <= '0;
            end else if ((state == S_PAYLOAD) && FIFO_EMPTY && (issued < len_q)
                         && !to_flag && (TIMEOUT != '0)) begin
                stall_cnt <= stall_cnt + TO_WIDTH'(1);
                if (stall_cnt + TO_WIDTH'(1) == TIMEOUT) begin
                    to_flag <= 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (ENABLE && !FIFO_EMPTY) begin
                        state     <= S_HEADER;
                        len_q     <= (FRAME_LEN == '0) ? LEN_WIDTH'(1) : FRAME_LEN;
                        chan_q    <= CHANNEL_ID;
                        sent      <= '0;
                        issued    <= '0;
                        stall_cnt <= '0;
                        to_flag   <= 1'b0;
                    end
                end
                S_HEADER: begin
                    if (OUT_READY) begin
                        state <= S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    if (pop && (sent + LEN_WIDTH'(1) == len_q)) begin
                        state <= S_TRAILER;
                    end else if (to_flag && (buf_cnt == '0) && (inflight == '0)) begin
                        state <= S_TRAILER;
                    end
                end
                S_TRAILER: begin
                    if (OUT_READY) begin
                        state   <= S_IDLE;
                        seq_q   <= seq_q + 16'd1;
                        to_flag <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_frame_reader.sv
module tb_fifo_frame_reader;

    localparam int RD_LATENCY = 1;
    localparam int DEPTH      = RD_LATENCY + 1;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        ENABLE = 1'b0;
    logic [7:0]  CHANNEL_ID = '0;
    logic [15:0] FRAME_LEN = '0;
    logic [15:0] TIMEOUT = '0;
    logic        FIFO_EMPTY = 1'b1;
    logic [63:0] FIFO_Q = '0;
    logic        FIFO_RE;
    logic [63:0] OUT_DATA;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b1;
    logic        OUT_LAST;
    logic        BUSY;
    logic [15:0] FRAME_SEQ;

    always #5 CLK = ~CLK;

    fifo_frame_reader #(.RD_LATENCY(RD_LATENCY)) dut (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .CHANNEL_ID(CHANNEL_ID),
        .FRAME_LEN(FRAME_LEN), .TIMEOUT(TIMEOUT), .FIFO_EMPTY(FIFO_EMPTY),
        .FIFO_Q(FIFO_Q), .FIFO_RE(FIFO_RE), .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY), .OUT_LAST(OUT_LAST), .BUSY(BUSY), .FRAME_SEQ(FRAME_SEQ)
    );

    typedef struct {
        logic [15:0] len;
        logic [7:0]  chan;
        logic [15:0] tmo;
        int          nwords;
        bit          rmode;
        logic [15:0] exp_len;
        int          exp_count;
        bit          exp_to;
        bit          contig;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] fq[$];
    logic [63:0] pend_q;
    bit          re_prev = 0;
    bit          ready_mode = 0;
    int          cyc = 0;
    bit          stall_prev = 0;
    logic [63:0] stall_dat;
    logic        stall_last;
    int          issued_tot = 0;
    int          payx = 0;
    bit          hdr_seen = 0;
    logic [15:0] exp_seq = '0;
    logic [63:0] cap_dat[$];
    bit          cap_last[$];
    int          cap_cyc[$];
    int          re_cnt = 0;

    function automatic logic [63:0] word(input logic [7:0] chan, input int i);
        return {chan, 8'hC3, 16'hBEEF, 16'(i), ~16'(i)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock: drive FIFO side and ready at negedge, observe 1ns later.
    task automatic step();
        bit xfer;
        bit pay;
        @(negedge CLK);
        cyc++;
        if (re_prev) FIFO_Q = pend_q;
        FIFO_EMPTY = (fq.size() == 0);
        OUT_READY  = ready_mode ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
        #1;
        if (stall_prev) begin
            chk("hold_valid", 64'(OUT_VALID), 64'd1);
            chk("hold_data", OUT_DATA, stall_dat);
            chk("hold_last", 64'(OUT_LAST), 64'(stall_last));
        end
        stall_prev = OUT_VALID && !OUT_READY;
        stall_dat  = OUT_DATA;
        stall_last = OUT_LAST;
        xfer = OUT_VALID && OUT_READY;
        pay  = xfer && hdr_seen && !OUT_LAST;
        if (xfer) begin
            cap_dat.push_back(OUT_DATA);
            cap_last.push_back(OUT_LAST);
            cap_cyc.push_back(cyc);
            if (!hdr_seen) hdr_seen = 1;
            else if (OUT_LAST) hdr_seen = 0;
            if (pay) payx++;
        end
        re_prev = FIFO_RE;
        if (FIFO_RE) begin
            re_cnt++;
            issued_tot++;
            chk("re_not_empty", 64'(FIFO_EMPTY), 64'd0);
            chk("read_credit", 64'(issued_tot - payx <= DEPTH), 64'd1);
            if (fq.size() > 0) pend_q = fq.pop_front();
        end
    endtask

    task automatic start_frame(input vec_t v);
        for (int i = 0; i < v.nwords; i++) fq.push_back(word(v.chan, i));
        ready_mode = v.rmode;
        TIMEOUT    = v.tmo;
        CHANNEL_ID = v.chan;
        FRAME_LEN  = v.len;
        step();
        cap_dat.delete();
        cap_last.delete();
        cap_cyc.delete();
        re_cnt = 0;
        ENABLE = 1'b1;
        step();
        ENABLE = 1'b0;
        CHANNEL_ID = 8'hEE;
        FRAME_LEN  = 16'd99;
    endtask

    task automatic run_frame(input vec_t v);
        int n;
        int budget;
        bit done;
        start_frame(v);
        budget = 0;
        done = (cap_last.size() > 0) && cap_last[cap_last.size()-1];
        while (!done && budget < 3000) begin
            step();
            budget++;
            done = (cap_last.size() > 0) && cap_last[cap_last.size()-1];
        end
        chk("frame_done", 64'(done), 64'd1);
        step();
        n = cap_dat.size();
        chk("xfer_count", 64'(n), 64'(v.exp_count + 2));
        if (n >= 2) begin
            chk("header", cap_dat[0], {8'hA5, v.chan, exp_seq, v.exp_len, 16'h0});
            for (int i = 0; i < v.exp_count && i + 2 < n; i++)
                chk("payload", cap_dat[i+1], word(v.chan, i));
            for (int i = 0; i < n; i++)
                chk("last_flag", 64'(cap_last[i]), 64'(i == n - 1));
            chk("trailer", cap_dat[n-1],
                {8'h5A, v.chan, exp_seq, 16'(v.exp_count), 15'h0, v.exp_to});
            if (v.contig)
                chk("no_bubble", 64'(cap_cyc[n-1] - cap_cyc[1]), 64'(v.exp_count));
        end
        chk("re_count", 64'(re_cnt), 64'(v.exp_count));
        exp_seq = exp_seq + 16'd1;
        chk("frame_seq", 64'(FRAME_SEQ), 64'(exp_seq));
        chk("busy_idle", 64'(BUSY), 64'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 64'(OUT_VALID), 64'd0);
        chk({tag, "_data"}, OUT_DATA, 64'd0);
        chk({tag, "_last"}, 64'(OUT_LAST), 64'd0);
        chk({tag, "_re"}, 64'(FIFO_RE), 64'd0);
        chk({tag, "_busy"}, 64'(BUSY), 64'd0);
        chk({tag, "_seq"}, 64'(FRAME_SEQ), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        vec_t tbl[5];
        vec_t v;
        int   base;
        int   budget;

        //          len    chan   tmo    nw  rm exp_len cnt to contig
        tbl[0] = '{16'd4,  8'h11, 16'd0,  4, 0, 16'd4,  4, 0, 1};  // basic frame
        tbl[1] = '{16'd4,  8'h22, 16'd0,  4, 1, 16'd4,  4, 0, 0};  // ready 1,0,0,1
        tbl[2] = '{16'd8,  8'h33, 16'd10, 3, 0, 16'd8,  3, 1, 0};  // starved, watchdog
        tbl[3] = '{16'd0,  8'h44, 16'd0,  1, 0, 16'd1,  1, 0, 1};  // zero length
        tbl[4] = '{16'd64, 8'h55, 16'd0, 64, 0, 16'd64, 64, 0, 1}; // full-rate stream

        RESET = 1'b1;
        repeat (3) step();
        RESET = 1'b0;
        step();
        chk_all_zero("reset");

        for (int k = 0; k < 5; k++) run_frame(tbl[k]);

        // Reset in the middle of a payload burst.
        v = '{16'd4, 8'h66, 16'd0, 4, 0, 16'd4, 4, 0, 1};
        start_frame(v);
        base = payx;
        budget = 0;
        while (payx - base < 2 && budget < 200) begin
            step();
            budget++;
        end
        chk("mid_frame_reached", 64'(payx - base >= 2), 64'd1);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        chk_all_zero("midreset");
        fq.delete();
        hdr_seen   = 0;
        stall_prev = 0;
        issued_tot = 0;
        payx       = 0;
        exp_seq    = '0;
        step();
        run_frame('{16'd2, 8'h67, 16'd0, 2, 0, 16'd2, 2, 0, 1});

        // Sequence counter wrap.
        force dut.seq_q = 16'hFFFF;
        step();
        release dut.seq_q;
        step();
        chk("seq_preset", 64'(FRAME_SEQ), 64'hFFFF);
        exp_seq = 16'hFFFF;
        run_frame('{16'd1, 8'h77, 16'd0, 1, 0, 16'd1, 1, 0, 1});
        chk("seq_wrapped", 64'(FRAME_SEQ), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
